// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and widths for the iterative RV32M multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_e;
endpackage

// File: rtl/muldiv_iter.sv
// One combinational shift/add (multiply) or restoring shift/subtract (divide) step on the 64-bit accumulator.
// Multiply: {hi,lo} holds {partial product, remaining multiplier}; divide: {remainder, dividend/quotient}.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic              is_div_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_diff;
  logic            rem_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // Shifted remainder can reach 33 bits; the difference always fits in 32 when taken.
    rem_sh   = acc_i[2*XLEN-1:XLEN-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_i});
    rem_diff = rem_sh[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      if (rem_ge) acc_o = {rem_diff, acc_i[XLEN-2:0], 1'b1};
      else        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: 34-cycle latency (2 for divide specials), result held in DONE
// until resp_ready; req_ready only in IDLE; kill aborts from any state.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  md_state_e         state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              busy_q;

  logic              is_div, sgn1, sgn2, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic              special_d;
  logic [2*XLEN-1:0] acc_init_d;
  logic [XLEN-1:0]   opnd_init_d;
  logic              neg_init_d;
  logic [2*XLEN-1:0] acc_step_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   word;
  logic [XLEN-1:0]   result_d;

  muldiv_iter u_iter (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (op_q[2]),
    .acc_o    (acc_step_d)
  );

  // Accept-side decode: magnitudes, result sign and the divide special cases.
  always_comb begin
    is_div = op[2];
    sgn1   = is_div ? ~op[0] : (op != MD_MULHU);
    sgn2   = is_div ? ~op[0] : ((op == MD_MUL) || (op == MD_MULH));
    a_neg  = sgn1 & rs1[XLEN-1];
    b_neg  = sgn2 & rs2[XLEN-1];
    mag1   = a_neg ? -rs1 : rs1;
    mag2   = b_neg ? -rs2 : rs2;
    div0   = is_div && (rs2 == '0);
    ovf    = is_div && !op[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == {XLEN{1'b1}});
    special_d   = div0 || ovf;
    acc_init_d  = '0;
    opnd_init_d = '0;
    neg_init_d  = 1'b0;
    // Specials preload {remainder, quotient} so FIXUP just selects the word.
    if (div0) begin
      acc_init_d = {rs1, {XLEN{1'b1}}};
    end else if (ovf) begin
      acc_init_d = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
    end else if (is_div) begin
      acc_init_d  = {{XLEN{1'b0}}, mag1};
      opnd_init_d = mag2;
      neg_init_d  = op[1] ? a_neg : (a_neg ^ b_neg);
    end else begin
      acc_init_d  = {{XLEN{1'b0}}, mag2};
      opnd_init_d = mag1;
      neg_init_d  = a_neg ^ b_neg;
    end
  end

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    word = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (!op_q[2]) result_d = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else          result_d = neg_q ? -word : word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      opnd_q       <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      resp_data_q  <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (kill) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready_q) begin
            op_q        <= op;
            acc_q       <= acc_init_d;
            opnd_q      <= opnd_init_d;
            neg_q       <= neg_init_d;
            cnt_q       <= '0;
            state_q     <= special_d ? ST_FIXUP : ST_CALC;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        ST_CALC: begin
          acc_q <= acc_step_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= ST_FIXUP;
        end
        ST_FIXUP: begin
          resp_data_q  <= result_d;
          resp_valid_q <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M cases, random ops against a 64-bit arithmetic model,
// backpressure, kill and mid-operation reset.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .rs1        (rs1),
    .rs2        (rs2),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    r  = '0;
    case (o)
      MD_MUL:    begin p = sa * sb; r = p[31:0];  end
      MD_MULH:   begin p = sa * sb; r = p[63:32]; end
      MD_MULHSU: begin p = sa * ub; r = p[63:32]; end
      MD_MULHU:  begin p = ua * ub; r = p[63:32]; end
      MD_DIV:    r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000
                                             : 32'($signed(a) / $signed(b));
      MD_REM:    r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0
                                  : 32'($signed(a) % $signed(b));
      MD_DIVU:   r = (b == 0) ? 32'hFFFFFFFF : a / b;
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 2;
    return 34;
  endfunction

  // Latency counts clock edges from the accept edge (1) to the edge that raises resp_valid.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string tag);
    int n;
    logic bad;
    logic [31:0] got;
    exp_q.push_back(exp);
    lat_q.push_back(exp_lat);
    @(negedge clk);
    resp_ready = (hold == 0);
    chk({tag, "_rdy_idle"}, req_ready, 1);
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 3'($urandom_range(0, 7));
    n = 1; bad = 1'b0;
    while (!resp_valid && n < 200) begin
      if (!busy || req_ready) bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_busy"}, bad, 0);
    chk({tag, "_vld"}, resp_valid, 1);
    got = resp_data;
    chk({tag, "_data"}, got, exp_q.pop_front());
    chk({tag, "_lat"}, n, lat_q.pop_front());
    if (hold > 0) begin
      bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (!resp_valid || resp_data !== got || !busy) bad = 1'b1;
      end
      chk({tag, "_hold"}, bad, 0);
      @(negedge clk);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, resp_valid, 0);
    chk({tag, "_rdy_back"}, req_ready, 1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic        bad;
    reset_n = 1'b0; req_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; kill = 1'b0; resp_ready = 1'b1;
    #12;
    chk("rst_rdy", req_ready, 1);
    chk("rst_vld", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", resp_data, 0);
    @(negedge clk); reset_n = 1'b1;

    run_op(MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0, "mul");
    run_op(MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, 0, "mulh");
    run_op(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0, "mulhu");
    run_op(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0, "mulhsu");
    run_op(MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0, "div");
    run_op(MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0, "rem");
    run_op(MD_DIVU,   32'd100,      32'd7,        32'd14,       34, 0, "divu");
    run_op(MD_REMU,   32'd100,      32'd7,        32'd2,        34, 0, "remu");
    run_op(MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2,  0, "divu0");
    run_op(MD_REM,    32'd5,        32'd0,        32'd5,        2,  0, "rem0");
    run_op(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  0, "div_ovf");
    run_op(MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        2,  0, "rem_ovf");

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)));
      run_op(ro, ra, rb, ref_md(ro, ra, rb), ref_lat(ro, ra, rb), 0, "rand");
    end

    run_op(MD_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34, 5, "bp");

    // Kill in the tenth CALC cycle: nothing may come back.
    @(negedge clk);
    req_valid = 1'b1; op = MD_MUL; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_rdy", req_ready, 1);
    chk("kill_busy", busy, 0);
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid || busy) bad = 1'b1;
    end
    chk("kill_no_resp", bad, 0);

    @(negedge clk);
    req_valid = 1'b1; op = MD_MULHU; rs1 = 32'hFFFF0000; rs2 = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_rdy", req_ready, 1);
    chk("mrst_vld", resp_valid, 0);
    chk("mrst_data", resp_data, 0);
    @(negedge clk); reset_n = 1'b1;
    run_op(MD_MUL, 32'd3, 32'd4, 32'd12, 34, 0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- Decode routes OPC_ARI_RTYPE instructions with funct7=0000001 here instead of to the ALU. The funct3 field is passed through as op.
- The block sequences a shared 64-bit shift/add datapath over 32 iterations and holds the result until writeback accepts it.
- It drives the busy signal that stalls the pipeline.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported.
- CNT_W, 6, width of the iteration counter. Must hold XLEN.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  an operation is presented.
- req_ready  output  1  the block accepts an operation (high only in IDLE).
- op  input  3  funct3 encoding: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- rs1  input  XLEN  first operand (multiplicand or dividend).
- rs2  input  XLEN  second operand (multiplier or divisor).
- kill  input  1  flush: abandon any in-flight operation.
- resp_valid  output  1  the result is valid.
- resp_ready  input  1  the consumer takes the result.
- resp_data  output  XLEN  the result.
- busy  output  1  asserted in any state other than IDLE. Drives the pipeline stall.

Behaviour:
- States and transitions:
  - States are IDLE, CALC, FIXUP, DONE.
  - Reset (asynchronous, reset_n=0) forces IDLE, counter=0, all datapath registers=0, resp_data=0.
  - Output values during and after reset: req_ready=1, resp_valid=0, busy=0.
  - IDLE: accept when req_valid && req_ready && !kill. On accept, latch op and the operand magnitudes (absolute value for signed operands), latch the result-sign flags, and clear the counter.
    - If the op is a divide with rs2==0, or DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF, go to FIXUP (special case).
    - Otherwise go to CALC.
  - CALC: one iteration per cycle, counter increments. Leave for FIXUP when counter==XLEN-1.
    - Multiply: shift-add on a 64-bit product register.
    - Divide: restoring, one quotient bit per cycle.
  - FIXUP (one cycle): conditionally negate the result and select the output word, then register resp_data and go to DONE.
  - DONE: resp_valid=1 and resp_data is held stable. When resp_ready=1, go to IDLE the next cycle.
- Latency from the accept edge to the first cycle of resp_valid:
  - Normal operation: 34 cycles (32 CALC + 1 FIXUP + 1).
  - Special case: 2 cycles.
- There is a minimum 1-cycle bubble between a response handshake and the next accept, because req_ready is high only in IDLE.
- Result rules:
  - MUL: low 32 bits of the product.
  - MULH, MULHSU, MULHU: high 32 bits. Signedness: MULH is signed×signed, MULHSU is signed rs1 × unsigned rs2, MULHU is unsigned×unsigned. The 64-bit product is negated when exactly one signed operand is negative.
  - DIV/REM: truncate toward zero. The quotient is negative iff the operand signs differ (and the divisor is nonzero). The remainder takes the sign of the dividend.
  - Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU). Remainder=rs1 (REM and REMU).
  - Overflow (DIV/REM only): quotient=0x80000000, remainder=0.
- kill: in any state, kill=1 forces IDLE at the next edge.
  - Any pending result is dropped and resp_valid is deasserted at that edge.
  - kill takes priority over both req_valid and resp_ready in the same cycle.
- Operands and op are sampled only at accept. Input changes during CALC have no effect.
- An illegal condition cannot occur: all 8 op codes are defined.

Decomposition:
- Shared package muldiv_pkg holds:
  - op localparams MD_MUL … MD_REMU.
  - The state encoding: IDLE=2'd0, CALC=2'd1, FIXUP=2'd2, DONE=2'd3.
  - XLEN.
- Sub-module muldiv_iter (combinational, one iteration):
  - Inputs: the 64-bit accumulator, the operand, and an is_div flag.
  - Outputs: the next accumulator.
  - Multiply step: conditional add of the multiplicand to the upper half, then a right shift.
  - Divide step: left shift, trial subtract, then set the quotient bit.
- The top level holds the FSM, the counter, the sign/negate logic and the output register.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → resp_data=0xFFFFFFEB, resp_valid first high 34 cycles after accept. busy=1 throughout and req_ready=0 throughout.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM 0xFFFFFFF9/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM with the same operands → 0. All four with latency 2.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE → resp_valid and resp_data stay stable. Then resp_ready=1 → IDLE next cycle, req_ready=1 after a 1-cycle bubble.
- kill at CALC cycle 10 → no resp_valid, req_ready=1 the next cycle. reset_n pulsed low mid-CALC → immediate IDLE, resp_data=0, then a fresh MUL 3×4 → 12.
